// File: rtl/reg_display_source.sv
// reg_display_source: register-display character source.
// Snoops CPU register-file writes into an 8 x 16-bit shadow and tracks which
// registers changed since the last frame. Each refresh takes a coherent
// snapshot and streams "R<n>: HHHH" glyph codes for every changed (or, with
// force_all, every) register line to the character/pixel writer.
//
// Handshake: char_valid/char_code/char_row/char_col form one valid/ready
// channel. A character transfers on a rising edge where char_valid and
// char_ready are both high. Once char_valid is raised it stays high and the
// payload stays stable until that transfer. char_ready may change freely.
module reg_display_source #(
  parameter int R_CODE     = 52,
  parameter int COLON_CODE = 17,
  parameter int SPACE_CODE = 18
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reg_wr_en,
  input  logic [2:0]  reg_wr_addr,
  input  logic [15:0] reg_wr_data,
  input  logic        refresh_req,
  input  logic        force_all,
  input  logic        char_ready,
  output logic        char_valid,
  output logic [7:0]  char_code,
  output logic [2:0]  char_row,
  output logic [2:0]  char_col,
  output logic        busy,
  output logic        frame_done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] R_C     = 8'(R_CODE);
  localparam logic [7:0] COLON_C = 8'(COLON_CODE);
  localparam logic [7:0] SPACE_C = 8'(SPACE_CODE);

  state_t      state;
  logic        force_q;
  logic [15:0] shadow   [8];
  logic [15:0] snapshot [8];
  logic [7:0]  dirty;
  logic [7:0]  pending;

  logic [7:0]  wr_mask;
  logic [7:0]  pending_rest;
  logic [2:0]  first_row;
  logic [2:0]  next_row;

  // Glyph code for one column of a register line "R<n>: HHHH".
  function automatic logic [7:0] glyph(input logic [2:0]  row,
                                       input logic [2:0]  col,
                                       input logic [15:0] data);
    logic [7:0] g;
    g = 8'd0;
    case (col)
      3'd0:    g = R_C;
      3'd1:    g = {5'd0, row};
      3'd2:    g = COLON_C;
      3'd3:    g = SPACE_C;
      3'd4:    g = {4'd0, data[15:12]};
      3'd5:    g = {4'd0, data[11:8]};
      3'd6:    g = {4'd0, data[7:4]};
      default: g = {4'd0, data[3:0]};
    endcase
    return g;
  endfunction

  // Index of the lowest set bit (0 when none is set; callers check for zero).
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Row selection: first row of a frame and the row following the current one.
  always_comb begin
    wr_mask      = reg_wr_en ? (8'd1 << reg_wr_addr) : 8'd0;
    pending_rest = pending & ~(8'd1 << char_row);
    first_row    = lowest_idx(pending);
    next_row     = lowest_idx(pending_rest);
  end

  // Shadow register file and dirty tracking; snooped in every state.
  // In the snapshot cycle dirty restarts from this cycle's write alone, so a
  // write landing during the snapshot is drawn by the following frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) shadow[i] <= 16'd0;
      dirty <= 8'hFF;
    end else begin
      if (reg_wr_en) shadow[reg_wr_addr] <= reg_wr_data;
      if (state == ST_SNAP) dirty <= wr_mask;
      else                  dirty <= dirty | wr_mask;
    end
  end

  // Frame sequencer with registered character channel and status outputs.
  // The first EMIT cycle has char_valid low; it either loads the first row or
  // finishes an empty frame. After that char_valid stays high across row
  // boundaries until the final column-7 transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      force_q    <= 1'b0;
      pending    <= 8'd0;
      char_valid <= 1'b0;
      char_code  <= 8'd0;
      char_row   <= 3'd0;
      char_col   <= 3'd0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 8; i++) snapshot[i] <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (refresh_req) begin
            force_q <= force_all;
            busy    <= 1'b1;
            state   <= ST_SNAP;
          end
        end
        ST_SNAP: begin
          for (int i = 0; i < 8; i++) snapshot[i] <= shadow[i];
          pending <= force_q ? 8'hFF : dirty;
          state   <= ST_EMIT;
        end
        ST_EMIT: begin
          if (!char_valid) begin
            if (pending == 8'd0) begin
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              char_valid <= 1'b1;
              char_row   <= first_row;
              char_col   <= 3'd0;
              char_code  <= glyph(first_row, 3'd0, snapshot[first_row]);
            end
          end else if (char_ready) begin
            if (char_col != 3'd7) begin
              char_col  <= char_col + 3'd1;
              char_code <= glyph(char_row, char_col + 3'd1, snapshot[char_row]);
            end else begin
              pending  <= pending_rest;
              char_col <= 3'd0;
              if (pending_rest != 8'd0) begin
                char_row  <= next_row;
                char_code <= glyph(next_row, 3'd0, snapshot[next_row]);
              end else begin
                char_valid <= 1'b0;
                frame_done <= 1'b1;
                state      <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

  // Channel and status invariants.
  a_hold_while_stalled: assert property (@(posedge clock) disable iff (reset)
    (char_valid && !char_ready) |=> (char_valid && $stable(char_code) &&
                                     $stable(char_row) && $stable(char_col)));
  a_done_single_cycle: assert property (@(posedge clock) disable iff (reset)
    frame_done |=> !frame_done);
  a_busy_matches_state: assert property (@(posedge clock) disable iff (reset)
    busy == (state != ST_IDLE));

endmodule

// File: tb/tb_reg_display_source.sv
// Testbench for reg_display_source: table of refresh frames plus hand-written
// sequences for snapshot coherence, held refresh, and reset mid-row.
module tb_reg_display_source;

  localparam logic [7:0] R_C   = 8'd52;
  localparam logic [7:0] COL_C = 8'd17;
  localparam logic [7:0] SP_C  = 8'd18;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        reg_wr_en;
  logic [2:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic        refresh_req;
  logic        force_all;
  logic        char_ready;
  logic        char_valid;
  logic [7:0]  char_code;
  logic [2:0]  char_row;
  logic [2:0]  char_col;
  logic        busy;
  logic        frame_done;
  logic [1:0]  dbg_state;

  always #5 clock = ~clock;

  reg_display_source dut (
    .clock       (clock),
    .reset       (reset),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .refresh_req (refresh_req),
    .force_all   (force_all),
    .char_ready  (char_ready),
    .char_valid  (char_valid),
    .char_code   (char_code),
    .char_row    (char_row),
    .char_col    (char_col),
    .busy        (busy),
    .frame_done  (frame_done),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entries are {row, col, code}.
  logic [13:0] exp_q[$];
  logic [15:0] m_shadow [8];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_glyph(input int r, input int c, input logic [15:0] d);
    case (c)
      0:       return R_C;
      1:       return 8'(r);
      2:       return COL_C;
      3:       return SP_C;
      4:       return {4'd0, d[15:12]};
      5:       return {4'd0, d[11:8]};
      6:       return {4'd0, d[7:4]};
      default: return {4'd0, d[3:0]};
    endcase
  endfunction

  task automatic push_frame(input logic [7:0] rows);
    for (int r = 0; r < 8; r++)
      if (rows[r])
        for (int c = 0; c < 8; c++)
          exp_q.push_back({3'(r), 3'(c), exp_glyph(r, c, m_shadow[r])});
  endtask

  // ---------------- driver tasks ----------------
  // Single register write in its own cycle (called at a negedge).
  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    reg_wr_en   = 1'b1;
    reg_wr_addr = a;
    reg_wr_data = d;
    m_shadow[a] = d;
    @(negedge clock);
    reg_wr_en = 1'b0;
  endtask

  // One refresh frame. cyc 1 is the cycle after the request edge.
  // Optional writes at cycles w1_cyc / w2_cyc (0 = none) and an optional
  // extra refresh pulse at cycle 5 that must be ignored.
  task automatic run_frame(input logic fa, input int ready_pct, input logic [7:0] rows,
                           input int w1_cyc, input logic [2:0] w1_a, input logic [15:0] w1_d,
                           input int w2_cyc, input logic [2:0] w2_a, input logic [15:0] w2_d,
                           input logic pulse_mid);
    int cyc, first_v, last_hs, fd_cyc, v_cnt, nchars;
    logic done, pv, pr;
    logic [13:0] pout, cur;
    exp_q.delete();
    push_frame(rows);
    nchars = exp_q.size();
    refresh_req = 1'b1;
    force_all   = fa;
    @(negedge clock);
    refresh_req = 1'b0;
    force_all   = 1'b0;
    cyc = 1; first_v = -1; last_hs = -1; fd_cyc = -1; v_cnt = 0;
    done = 1'b0; pv = 1'b0; pr = 1'b0; pout = '0;
    while (!done && cyc < 400) begin
      cur = {char_row, char_col, char_code};
      if (pv && !pr) check("stall_hold", 32'({char_valid, cur}), 32'({1'b1, pout}));
      check("busy_in_frame", 32'(busy), 32'd1);
      if (char_valid) begin
        v_cnt++;
        if (first_v < 0) begin
          first_v = cyc;
          check("first_valid_cyc", 32'(cyc), (rows == 8'd0) ? 32'd0 : 32'd3);
        end
      end
      char_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < 32'(ready_pct));
      if (char_valid && char_ready) begin
        if (exp_q.size() == 0) check("extra_char", 32'd1, 32'd0);
        else                   check("char", 32'(cur), 32'(exp_q.pop_front()));
        last_hs = cyc;
      end
      reg_wr_en = 1'b0;
      if (cyc == w1_cyc) begin
        reg_wr_en = 1'b1; reg_wr_addr = w1_a; reg_wr_data = w1_d; m_shadow[w1_a] = w1_d;
      end
      if (cyc == w2_cyc) begin
        reg_wr_en = 1'b1; reg_wr_addr = w2_a; reg_wr_data = w2_d; m_shadow[w2_a] = w2_d;
      end
      refresh_req = pulse_mid && (cyc == 5);
      if (frame_done) begin
        done   = 1'b1;
        fd_cyc = cyc;
      end
      pv = char_valid; pr = char_ready; pout = cur;
      @(negedge clock);
      cyc++;
    end
    reg_wr_en   = 1'b0;
    refresh_req = 1'b0;
    char_ready  = 1'b1;
    if (!done) begin
      check("frame_timeout", 32'd0, 32'd1);
    end else begin
      check("frame_done_cyc", 32'(fd_cyc), (rows == 8'd0) ? 32'd3 : 32'(last_hs + 1));
      check("chars_left", 32'(exp_q.size()), 32'd0);
      if (ready_pct >= 100) check("valid_cycles", 32'(v_cnt), 32'(nchars));
      check("fd_one_cycle", 32'(frame_done), 32'd0);
      check("busy_after", 32'(busy), 32'd0);
      if (pulse_mid) begin
        repeat (2) begin
          @(negedge clock);
          check("no_queued_req", 32'(busy), 32'd0);
        end
      end
    end
  endtask

  // ---------------- frame table ----------------
  typedef struct {
    logic        wr_en;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        fa;
    int          ready_pct;
    logic        pulse;
    logic [7:0]  exp_rows;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // First frame after reset draws everything; later frames follow dirty.
    vecs[0] = '{1'b0, 3'd0, 16'h0000, 1'b0, 100, 1'b0, 8'hFF};
    vecs[1] = '{1'b1, 3'd3, 16'hA5C1, 1'b0, 100, 1'b0, 8'h08};
    vecs[2] = '{1'b0, 3'd0, 16'h0000, 1'b0, 100, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 3'd7, 16'hFFFF, 1'b1,  40, 1'b0, 8'hFF};
    vecs[4] = '{1'b1, 3'd0, 16'h1234, 1'b0,  60, 1'b0, 8'h01};
    vecs[5] = '{1'b0, 3'd0, 16'h0000, 1'b1, 100, 1'b0, 8'hFF};
    vecs[6] = '{1'b1, 3'd4, 16'h0BEE, 1'b0, 100, 1'b1, 8'h10};
    vecs[7] = '{1'b1, 3'd7, 16'h8001, 1'b0, 100, 1'b1, 8'h80};

    reset = 1'b1; reg_wr_en = 1'b0; reg_wr_addr = 3'd0; reg_wr_data = 16'd0;
    refresh_req = 1'b0; force_all = 1'b0; char_ready = 1'b1;
    for (int i = 0; i < 8; i++) m_shadow[i] = 16'd0;
    repeat (2) @(negedge clock);

    // Reset values
    check("rst_valid", 32'(char_valid), 32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_done",  32'(frame_done), 32'd0);
    check("rst_code",  32'(char_code),  32'd0);
    check("rst_row",   32'(char_row),   32'd0);
    check("rst_col",   32'(char_col),   32'd0);
    check("rst_state", 32'(dbg_state),  32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].wr_en) write_reg(vecs[v].addr, vecs[v].data);
      run_frame(vecs[v].fa, vecs[v].ready_pct, vecs[v].exp_rows,
                0, 3'd0, 16'd0, 0, 3'd0, 16'd0, vecs[v].pulse);
    end

    // Writes during a frame: R2 in the snapshot cycle, R5 while emitting row 2.
    // The current frame shows the old values; the next one shows exactly 2 and 5.
    write_reg(3'd2, 16'h2BAD);
    write_reg(3'd5, 16'h5AFE);
    run_frame(1'b1, 100, 8'hFF, 1, 3'd2, 16'hC0DE, 20, 3'd5, 16'hFACE, 1'b0);
    run_frame(1'b0, 100, 8'h24, 0, 3'd0, 16'd0, 0, 3'd0, 16'd0, 1'b0);

    // Held refresh: frames back-to-back with a single IDLE cycle between.
    write_reg(3'd6, 16'h6006);
    exp_q.delete();
    push_frame(8'h40);
    refresh_req = 1'b1;
    char_ready  = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock);
      check("hold_fd",    32'(frame_done), 32'(c == 11 || c == 15 || c == 19 || c == 23));
      check("hold_busy",  32'(busy),       32'(!(c == 12 || c == 16 || c == 20 || c == 24)));
      check("hold_valid", 32'(char_valid), 32'(c >= 3 && c <= 10));
      if (char_valid && exp_q.size() > 0)
        check("hold_char", 32'({char_row, char_col, char_code}), 32'(exp_q.pop_front()));
    end
    refresh_req = 1'b0;
    check("hold_chars_left", 32'(exp_q.size()), 32'd0);
    @(negedge clock);

    // Reset in the middle of row 1.
    write_reg(3'd1, 16'hBEEF);
    refresh_req = 1'b1;
    force_all   = 1'b1;
    @(negedge clock);
    refresh_req = 1'b0;
    force_all   = 1'b0;
    repeat (12) @(negedge clock);
    check("pre_rst_valid", 32'(char_valid), 32'd1);
    check("pre_rst_pos",   32'({char_row, char_col}), 32'({3'd1, 3'd2}));
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(char_valid), 32'd0);
    check("mid_rst_busy",  32'(busy),       32'd0);
    check("mid_rst_done",  32'(frame_done), 32'd0);
    check("mid_rst_code",  32'(char_code),  32'd0);
    check("mid_rst_row",   32'(char_row),   32'd0);
    check("mid_rst_col",   32'(char_col),   32'd0);
    check("mid_rst_state", 32'(dbg_state),  32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_shadow[i] = 16'd0;
    @(negedge clock);
    run_frame(1'b0, 100, 8'hFF, 0, 3'd0, 16'd0, 0, 3'd0, 16'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
